// File: rtl/mem_arb_pkg.sv
// Shared types for mem_bus_arbiter: FSM state, grant-owner encoding and bus geometry.
package mem_arb_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned MASK_W     = DATA_W_DEF / 8;

    typedef enum logic [1:0] {
        IDLE,
        GNT_MEM,
        GNT_IF
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_MEM,
        OWN_IF
    } owner_t;

    // MEM always wins: its instruction is older in the pipeline than the fetch.
    function automatic owner_t arbitrate(input logic mem_pend, input logic if_pend);
        if (mem_pend) return OWN_MEM;
        if (if_pend) return OWN_IF;
        return OWN_NONE;
    endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Wait-state counter for mem_bus_arbiter; expire is high once TIMEOUT_CYC waits have elapsed.
module arb_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != CW'(TIMEOUT_CYC)) begin
            count <= count + CW'(1);
        end
    end

    assign expire = (count == CW'(TIMEOUT_CYC));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter between IF and MEM stages; MEM has priority.
// Optional transaction timeout with bus_err is enabled by defining BUS_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [DATA_W/8-1:0] mem_wmask,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_ready,
    output logic                bus_req,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_wmask,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ack,
    output logic                stall_IF,
    output logic                stall_MEM,
    output logic                bus_err
);
    state_t state;
    owner_t next_own;
    logic   if_kill;
    logic   ack_cur;
    logic   timeout;
    logic   done;
    logic   grant;
    logic   mem_pend;
    logic   if_pend;

    assign stall_IF  = if_req & ~if_ready;
    assign stall_MEM = mem_req & ~mem_ready;

    // A requester whose ready is pulsing still shows the completed request; it must not be refetched.
    assign mem_pend = mem_req & ~mem_ready;
    assign if_pend  = if_req & ~if_ready;

    assign ack_cur = bus_ack & (state != IDLE);

`ifdef BUS_TIMEOUT_EN
    logic expire;

    arb_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == IDLE || done),
        .enable(state != IDLE && !bus_ack),
        .expire(expire)
    );

    assign timeout = expire & ~ack_cur & (state != IDLE);
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    assign done  = ack_cur | timeout;
    assign grant = (state == IDLE) | done;

    always_comb begin
        next_own = OWN_NONE;
        if (state == IDLE) begin
            next_own = arbitrate(mem_pend, if_pend);
        end else if (done) begin
            next_own = arbitrate(mem_pend && state != GNT_MEM, if_pend && state != GNT_IF);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            if_kill   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_wmask <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            if_rdata  <= '0;
            if_ready  <= 1'b0;
            mem_rdata <= '0;
            mem_ready <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            bus_err   <= 1'b0;

            // A flushed fetch keeps the bus until ack but its result is dropped.
            if (state == GNT_IF && !if_req) if_kill <= 1'b1;

            if (done) begin
                bus_err <= timeout;
                if (state == GNT_MEM) begin
                    mem_ready <= 1'b1;
                    mem_rdata <= (timeout || bus_we) ? '0 : bus_rdata;
                end else if (!if_kill && if_req) begin
                    if_ready <= 1'b1;
                    if_rdata <= timeout ? '0 : bus_rdata;
                end
            end

            if (grant) begin
                if_kill <= 1'b0;
                case (next_own)
                    OWN_MEM: begin
                        state     <= GNT_MEM;
                        bus_req   <= 1'b1;
                        bus_we    <= mem_we;
                        bus_wmask <= mem_we ? mem_wmask : '0;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_we ? mem_wdata : '0;
                    end
                    OWN_IF: begin
                        state     <= GNT_IF;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_wmask <= '0;
                        bus_addr  <= if_addr;
                        bus_wdata <= '0;
                    end
                    default: begin
                        state     <= IDLE;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_wmask <= '0;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                    end
                endcase
            end
        end
    end

endmodule
